// File: rtl/verifier_compute_v1v2_pkg.sv
// Shared prime-field definitions (width, modulus, add/sub/mul) and the verifier FSM state encoding.
// Every field function returns a value strictly below F_Q when given operands below F_Q.
package verifier_compute_v1v2_pkg;

    localparam int F_NBITS = 16;
    localparam logic [F_NBITS-1:0] F_Q = 16'd65521;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [F_NBITS-1:0] f_add(input logic [F_NBITS-1:0] a, input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
        return s[F_NBITS-1:0];
    endfunction

    // a + F_Q - b never underflows, and a single conditional subtract brings it back into range
    function automatic logic [F_NBITS-1:0] f_sub(input logic [F_NBITS-1:0] a, input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, F_Q} - {1'b0, b};
        if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
        return s[F_NBITS-1:0];
    endfunction

    function automatic logic [F_NBITS-1:0] f_mul(input logic [F_NBITS-1:0] a, input logic [F_NBITS-1:0] b);
        logic [2*F_NBITS-1:0] p;
        p = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
        p = p % {{F_NBITS{1'b0}}, F_Q};
        return p[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/verifier_compute_v1v2_if.sv
// Request/result bundle between the verifier sequencer (master) and the V(w1)/V(w2) evaluator (slave).
interface verifier_compute_v1v2_if
    import verifier_compute_v1v2_pkg::*;
#(
    parameter int nInputs = 8,
    parameter int nInBits = $clog2(nInputs)
);
    logic                              en;
    logic [nInputs-1:0][F_NBITS-1:0]   in_vals;
    logic [nInBits-1:0][F_NBITS-1:0]   w1_vals;
    logic [nInBits-1:0][F_NBITS-1:0]   w2_vals;
    logic [F_NBITS-1:0]                v1_val;
    logic [F_NBITS-1:0]                v2_val;
    logic                              ready;

    modport master (output en, in_vals, w1_vals, w2_vals, input v1_val, v2_val, ready);
    modport slave  (input en, in_vals, w1_vals, w2_vals, output v1_val, v2_val, ready);
endinterface

// File: rtl/verifier_compute_v1v2_mle_fold_lane.sv
// One multilinear-extension fold lane: value table, captured point, one field multiply per cycle.
// fold_out is combinational from the current table/point; the table updates in place on fold.
module verifier_mle_fold_lane
    import verifier_compute_v1v2_pkg::*;
#(
    parameter  int nInBits = 3,
    localparam int N_TBL   = 1 << nInBits,
    localparam int RW      = (nInBits > 1) ? $clog2(nInBits) : 1
) (
    input  logic                             clk,
    input  logic                             load,
    input  logic                             fold,
    input  logic [N_TBL-1:0][F_NBITS-1:0]    vals,
    input  logic [nInBits-1:0][F_NBITS-1:0]  w_vals,
    input  logic [RW-1:0]                    round,
    input  logic [nInBits-1:0]               k,
    output logic [F_NBITS-1:0]               fold_out
);
    logic [F_NBITS-1:0]               tbl [N_TBL];
    logic [nInBits-1:0][F_NBITS-1:0]  w_q;
    logic [nInBits-1:0]               lo_idx;
    logic [nInBits-1:0]               hi_idx;
    logic [F_NBITS-1:0]               lo;
    logic [F_NBITS-1:0]               hi;

    // Writes land at k while reads come from 2k/2k+1, so in-place folding never clobbers unread data.
    assign lo_idx   = k << 1;
    assign hi_idx   = lo_idx | nInBits'(1);
    assign lo       = tbl[lo_idx];
    assign hi       = tbl[hi_idx];
    assign fold_out = f_add(lo, f_mul(w_q[round], f_sub(hi, lo)));

    always_ff @(posedge clk) begin
        if (load) begin
            for (int j = 0; j < N_TBL; j++) tbl[j] <= vals[j];
            w_q <= w_vals;
        end else if (fold) begin
            tbl[k] <= fold_out;
        end
    end
endmodule

// File: rtl/verifier_compute_v1v2.sv
// Evaluates the multilinear extension of in_vals at w1 and w2 with two lockstep fold lanes.
// en accepted in IDLE/DONE; ready and results appear 2^nInBits-1 edges later and hold until the next en.
module verifier_compute_v1v2
    import verifier_compute_v1v2_pkg::*;
#(
    parameter int nInputs = 8,
    parameter int nInBits = $clog2(nInputs)
) (
    input  logic                       clk,
    input  logic                       rstb,
    verifier_compute_v1v2_if.slave     bus
);
    localparam int N_TBL = 1 << nInBits;
    localparam int RW    = (nInBits > 1) ? $clog2(nInBits) : 1;

    state_t                        state, state_n;
    logic [RW-1:0]                 round, round_n;
    logic [nInBits-1:0]            k, k_n, k_last;
    logic                          ready_q, ready_n;
    logic [F_NBITS-1:0]            v1_q, v1_n, v2_q, v2_n;
    logic                          load, fold;
    logic [F_NBITS-1:0]            f1, f2;
    logic [N_TBL-1:0][F_NBITS-1:0] padded;
    logic [31:0]                   span;

    always_comb begin
        padded = '0;
        for (int j = 0; j < nInputs; j++) padded[j] = bus.in_vals[j];
    end

    verifier_mle_fold_lane #(.nInBits(nInBits)) u_lane1 (
        .clk(clk), .load(load), .fold(fold), .vals(padded), .w_vals(bus.w1_vals),
        .round(round), .k(k), .fold_out(f1)
    );

    verifier_mle_fold_lane #(.nInBits(nInBits)) u_lane2 (
        .clk(clk), .load(load), .fold(fold), .vals(padded), .w_vals(bus.w2_vals),
        .round(round), .k(k), .fold_out(f2)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= ST_IDLE;
            round   <= '0;
            k       <= '0;
            ready_q <= 1'b0;
            v1_q    <= '0;
            v2_q    <= '0;
        end else begin
            state   <= state_n;
            round   <= round_n;
            k       <= k_n;
            ready_q <= ready_n;
            v1_q    <= v1_n;
            v2_q    <= v2_n;
        end
    end

    always_comb begin
        state_n = state;
        round_n = round;
        k_n     = k;
        ready_n = ready_q;
        v1_n    = v1_q;
        v2_n    = v2_q;
        load    = 1'b0;
        fold    = 1'b0;
        // Round r halves the live table, so it ends at k = 2^(nInBits-1-r) - 1.
        span    = 32'(N_TBL) >> (32'(round) + 32'd1);
        k_last  = nInBits'(span - 32'd1);
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.en) begin
                    load    = 1'b1;
                    round_n = '0;
                    k_n     = '0;
                    ready_n = 1'b0;
                    state_n = ST_FOLD;
                end
            end
            ST_FOLD: begin
                fold = 1'b1;
                if (k == k_last) begin
                    k_n = '0;
                    if (round == RW'(nInBits - 1)) begin
                        round_n = '0;
                        ready_n = 1'b1;
                        v1_n    = f1;
                        v2_n    = f2;
                        state_n = ST_DONE;
                    end else begin
                        round_n = round + 1'b1;
                    end
                end else begin
                    k_n = k + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.ready  = ready_q;
    assign bus.v1_val = v1_q;
    assign bus.v2_val = v2_q;
endmodule

// File: tb/tb_verifier_compute_v1v2.sv
// Bench for verifier_compute_v1v2: directed cases, reset mid-fold, en hold/restart, randomized runs vs chi-sum model.
module tb_verifier_compute_v1v2;
    localparam longint unsigned Q = 65521;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    verifier_compute_v1v2_if #(.nInputs(8)) b8 ();
    verifier_compute_v1v2_if #(.nInputs(5)) b5 ();

    verifier_compute_v1v2 #(.nInputs(8)) dut8 (.clk(clk), .rstb(rstb), .bus(b8));
    verifier_compute_v1v2 #(.nInputs(5)) dut5 (.clk(clk), .rstb(rstb), .bus(b5));

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned iv [8];
    int unsigned w1 [3];
    int unsigned w2 [3];

    // Direct definition: sum_j v[j] * prod_b (bit b of j ? w[b] : 1 - w[b]) mod Q, zero beyond nin.
    function automatic int unsigned chi_sum(input int unsigned v[8], input int unsigned w[3], input int nin);
        longint unsigned acc = 0;
        longint unsigned prod;
        longint unsigned f;
        for (int j = 0; j < 8; j++) begin
            if (j < nin) begin
                prod = longint'(v[j]) % Q;
                for (int b = 0; b < 3; b++) begin
                    f    = ((j >> b) & 1) != 0 ? longint'(w[b]) : (1 + Q - longint'(w[b])) % Q;
                    prod = (prod * f) % Q;
                end
                acc = (acc + prod) % Q;
            end
        end
        return int'(acc);
    endfunction

    task automatic drive8();
        for (int j = 0; j < 8; j++) b8.in_vals[j] = 16'(iv[j]);
        for (int b = 0; b < 3; b++) begin
            b8.w1_vals[b] = 16'(w1[b]);
            b8.w2_vals[b] = 16'(w2[b]);
        end
    endtask

    task automatic randomize_vals();
        for (int j = 0; j < 8; j++) iv[j] = $urandom_range(0, int'(Q) - 1);
        for (int b = 0; b < 3; b++) begin
            w1[b] = $urandom_range(0, int'(Q) - 1);
            w2[b] = $urandom_range(0, int'(Q) - 1);
        end
    endtask

    // c is the index of the last posedge passed (en sampled at edge 0); stops when ready or budget expires.
    task automatic wait_ready8(inout int c);
        do begin
            @(negedge clk);
            c++;
        end while (b8.ready !== 1'b1 && c < 200);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (b8.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready8: got %0b expected 0", b8.ready); end
        n_checks++; if (b8.v1_val !== 16'd0) begin n_fail++; $display("FAIL reset_v1_8: got %0d expected 0", b8.v1_val); end
        n_checks++; if (b8.v2_val !== 16'd0) begin n_fail++; $display("FAIL reset_v2_8: got %0d expected 0", b8.v2_val); end
        n_checks++; if (b5.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready5: got %0b expected 0", b5.ready); end
        rstb = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (b8.ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready8: got %0b expected 0", b8.ready); end
        n_checks++; if (b5.v1_val !== 16'd0) begin n_fail++; $display("FAIL idle_v1_5: got %0d expected 0", b5.v1_val); end
    endtask

    task automatic test_directed();
        int c;
        logic [15:0] e1, e2;
        for (int tc = 0; tc < 2; tc++) begin
            for (int j = 0; j < 8; j++) iv[j] = j;
            if (tc == 0) begin
                w1 = '{0, 0, 0}; w2 = '{1, 1, 1}; e1 = 16'd0; e2 = 16'd7;
            end else begin
                w1 = '{1, 0, 0}; w2 = '{0, 0, 1}; e1 = 16'd1; e2 = 16'd4;
            end
            drive8();
            b8.en = 1'b1;
            @(negedge clk);
            b8.en = 1'b0;
            c = 0;
            wait_ready8(c);
            n_checks++; if (c != 7) begin n_fail++; $display("FAIL dir%0d_latency: got %0d edges expected 7", tc, c); end
            n_checks++; if (b8.v1_val !== e1) begin n_fail++; $display("FAIL dir%0d_v1: got %0d expected %0d", tc, b8.v1_val, e1); end
            n_checks++; if (b8.v2_val !== e2) begin n_fail++; $display("FAIL dir%0d_v2: got %0d expected %0d", tc, b8.v2_val, e2); end
        end
        // Five inputs: index 7 lies in the zero padding, index 4 holds 5
        for (int j = 0; j < 5; j++) b5.in_vals[j] = 16'(j + 1);
        for (int b = 0; b < 3; b++) begin
            b5.w1_vals[b] = 16'd1;
            b5.w2_vals[b] = (b == 2) ? 16'd1 : 16'd0;
        end
        b5.en = 1'b1;
        @(negedge clk);
        b5.en = 1'b0;
        c = 0;
        do begin @(negedge clk); c++; end while (b5.ready !== 1'b1 && c < 200);
        n_checks++; if (c != 7) begin n_fail++; $display("FAIL pad_latency: got %0d edges expected 7", c); end
        n_checks++; if (b5.v1_val !== 16'd0) begin n_fail++; $display("FAIL pad_v1: got %0d expected 0", b5.v1_val); end
        n_checks++; if (b5.v2_val !== 16'd5) begin n_fail++; $display("FAIL pad_v2: got %0d expected 5", b5.v2_val); end
    endtask

    task automatic test_reset_mid_fold();
        int c;
        int unsigned e1, e2;
        randomize_vals();
        drive8();
        b8.en = 1'b1;
        @(negedge clk);
        b8.en = 1'b0;
        repeat (2) @(negedge clk);
        rstb = 1'b0;
        #1;
        n_checks++; if (b8.ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %0b expected 0", b8.ready); end
        n_checks++; if (b8.v1_val !== 16'd0) begin n_fail++; $display("FAIL midrst_v1: got %0d expected 0", b8.v1_val); end
        n_checks++; if (b8.v2_val !== 16'd0) begin n_fail++; $display("FAIL midrst_v2: got %0d expected 0", b8.v2_val); end
        n_checks++; if (b5.ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready5: got %0b expected 0", b5.ready); end
        @(negedge clk);
        rstb = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (b8.ready !== 1'b0) begin n_fail++; $display("FAIL postrst_idle: got %0b expected 0", b8.ready); end
        randomize_vals();
        e1 = chi_sum(iv, w1, 8);
        e2 = chi_sum(iv, w2, 8);
        drive8();
        b8.en = 1'b1;
        @(negedge clk);
        b8.en = 1'b0;
        c = 0;
        wait_ready8(c);
        n_checks++; if (c != 7) begin n_fail++; $display("FAIL postrst_latency: got %0d edges expected 7", c); end
        n_checks++; if (b8.v1_val !== 16'(e1)) begin n_fail++; $display("FAIL postrst_v1: got %0d expected %0d", b8.v1_val, e1); end
        n_checks++; if (b8.v2_val !== 16'(e2)) begin n_fail++; $display("FAIL postrst_v2: got %0d expected %0d", b8.v2_val, e2); end
    endtask

    task automatic test_en_held();
        int c;
        int unsigned e1, e2;
        randomize_vals();
        e1 = chi_sum(iv, w1, 8);
        e2 = chi_sum(iv, w2, 8);
        drive8();
        b8.en = 1'b1;
        @(negedge clk);
        c = 0;
        repeat (4) begin
            @(negedge clk);
            c++;
            if (c == 2) begin
                randomize_vals();
                drive8();
            end
        end
        b8.en = 1'b0;
        wait_ready8(c);
        n_checks++; if (c != 7) begin n_fail++; $display("FAIL held_latency: got %0d edges expected 7", c); end
        n_checks++; if (b8.v1_val !== 16'(e1)) begin n_fail++; $display("FAIL held_v1: got %0d expected %0d", b8.v1_val, e1); end
        n_checks++; if (b8.v2_val !== 16'(e2)) begin n_fail++; $display("FAIL held_v2: got %0d expected %0d", b8.v2_val, e2); end
        randomize_vals();
        drive8();
        repeat (4) @(negedge clk);
        n_checks++; if (b8.ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready: got %0b expected 1", b8.ready); end
        n_checks++; if (b8.v1_val !== 16'(e1)) begin n_fail++; $display("FAIL hold_v1: got %0d expected %0d", b8.v1_val, e1); end
        n_checks++; if (b8.v2_val !== 16'(e2)) begin n_fail++; $display("FAIL hold_v2: got %0d expected %0d", b8.v2_val, e2); end
    endtask

    task automatic test_back_to_back();
        int c;
        int unsigned e1, e2;
        randomize_vals();
        e1 = chi_sum(iv, w1, 8);
        e2 = chi_sum(iv, w2, 8);
        drive8();
        b8.en = 1'b1;
        @(negedge clk);
        b8.en = 1'b0;
        n_checks++; if (b8.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_drop: got %0b expected 0", b8.ready); end
        c = 0;
        wait_ready8(c);
        n_checks++; if (c != 7) begin n_fail++; $display("FAIL b2b_latency: got %0d edges expected 7", c); end
        n_checks++; if (b8.v1_val !== 16'(e1)) begin n_fail++; $display("FAIL b2b_v1: got %0d expected %0d", b8.v1_val, e1); end
        n_checks++; if (b8.v2_val !== 16'(e2)) begin n_fail++; $display("FAIL b2b_v2: got %0d expected %0d", b8.v2_val, e2); end
    endtask

    task automatic test_random();
        int c;
        int unsigned e1, e2;
        for (int run = 0; run < 16; run++) begin
            randomize_vals();
            e1 = chi_sum(iv, w1, 8);
            e2 = chi_sum(iv, w2, 8);
            drive8();
            b8.en = 1'b1;
            @(negedge clk);
            b8.en = 1'b0;
            c = 0;
            wait_ready8(c);
            n_checks++; if (c != 7) begin n_fail++; $display("FAIL rand%0d_latency: got %0d edges expected 7", run, c); end
            n_checks++; if (b8.v1_val !== 16'(e1)) begin n_fail++; $display("FAIL rand%0d_v1: got %0d expected %0d", run, b8.v1_val, e1); end
            n_checks++; if (b8.v2_val !== 16'(e2)) begin n_fail++; $display("FAIL rand%0d_v2: got %0d expected %0d", run, b8.v2_val, e2); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        b8.en = 1'b0; b8.in_vals = '0; b8.w1_vals = '0; b8.w2_vals = '0;
        b5.en = 1'b0; b5.in_vals = '0; b5.w1_vals = '0; b5.w2_vals = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_reset_mid_fold();
        test_en_held();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
